// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding and
// counter sizing.
package seq_divider_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRun    = 2'd1,
        StFinish = 2'd2
    } state_e;

    // Wide enough to hold the value size itself.
    function automatic int unsigned cnt_width(input int unsigned size);
        return $clog2(size) + 1;
    endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Start/busy/done handshake and operand/result bus of the sequential divider.
interface seq_divider_if #(
    parameter int unsigned size = 4
);
    logic            start;
    logic [size-1:0] dividend;
    logic [size-1:0] divisor;
    logic [size-1:0] quotient;
    logic [size-1:0] remainder;
    logic            busy;
    logic            done;
    logic            div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, div_by_zero
    );
endinterface

// File: rtl/addsub_stage.sv
// Ripple add/subtract stage; cout=1 on subtract means no borrow occurred.
module addsub_stage #(
    parameter int unsigned width = 5
) (
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    input  logic             control,
    output logic [width-1:0] diff,
    output logic             cout
);
    logic [width:0] sum;

    // Subtract as a + ~b + 1; the extra top bit is the carry-out.
    always_comb begin
        sum = {1'b0, a} + {1'b0, b ^ {width{control}}} + {{width{1'b0}}, control};
    end

    assign diff = sum[width-1:0];
    assign cout = sum[width];
endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock, with a
// start/busy/done handshake and divide-by-zero flag.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int unsigned size = 4
) (
    input logic          clk,
    input logic          rst,
    seq_divider_if.slave bus
);
    localparam int unsigned cw = cnt_width(size);

    state_e          state;
    logic [size:0]   r_q;
    logic [size-1:0] q_q;
    logic [size-1:0] div_q;
    logic [cw-1:0]   cnt_q;
    logic [size-1:0] quotient_q;
    logic [size-1:0] remainder_q;
    logic            busy_q;
    logic            done_q;
    logic            dbz_q;

    logic [size:0]   r_shift;
    logic [size:0]   diff;
    logic [size:0]   r_next;
    logic            no_borrow;

    // Shift {R,Q} left: R picks up the quotient MSB.
    assign r_shift = (size+1)'({r_q, q_q[size-1]});

    addsub_stage #(
        .width (size + 1)
    ) u_sub (
        .a       (r_shift),
        .b       ({1'b0, div_q}),
        .control (1'b1),
        .diff    (diff),
        .cout    (no_borrow)
    );

    assign r_next = no_borrow ? diff : r_shift;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= StIdle;
            r_q         <= '0;
            q_q         <= '0;
            div_q       <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        div_q <= bus.divisor;
                        if (bus.divisor != '0) begin
                            r_q    <= '0;
                            q_q    <= bus.dividend;
                            cnt_q  <= cw'(size);
                            dbz_q  <= 1'b0;
                            busy_q <= 1'b1;
                            state  <= StRun;
                        end else begin
                            quotient_q  <= '1;
                            remainder_q <= bus.dividend;
                            dbz_q       <= 1'b1;
                            done_q      <= 1'b1;
                            state       <= StFinish;
                        end
                    end
                end
                StRun: begin
                    r_q   <= r_next;
                    q_q   <= {q_q[size-2:0], no_borrow};
                    cnt_q <= cnt_q - cw'(1);
                    // Last step: publish results so done and data appear together.
                    if (cnt_q == cw'(1)) begin
                        quotient_q  <= {q_q[size-2:0], no_borrow};
                        remainder_q <= r_next[size-1:0];
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        state       <= StFinish;
                    end
                end
                StFinish: begin
                    done_q <= 1'b0;
                    state  <= StIdle;
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= StIdle;
                end
            endcase
        end
    end

    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
endmodule
